// File: rtl/pipe_regfile.sv
// Two-read/one-write register file that zeroes itself with a one-entry-per-cycle sweep after reset or i_clr.
// Reads are combinational with same-cycle write bypass; writes land in one cycle; o_busy flags the sweep, no backpressure.
module pipe_regfile #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter bit ZERO_REG = 1'b1
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_clr,
    input  logic [ADDR_W-1:0] i_raddr1,
    input  logic [ADDR_W-1:0] i_raddr2,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    output logic [DATA_W-1:0] o_rdata1,
    output logic [DATA_W-1:0] o_rdata2,
    output logic              o_busy
);

    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] cnt;
    logic [DATA_W-1:0] mem [DEPTH];

    logic              wr_fire;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [DATA_W-1:0] mem_wdata;

    // A user write only counts in IDLE with no clear request; reset drops it too.
    assign wr_fire = i_rst_n && (state == ST_IDLE) && i_we && !i_clr
                     && !(ZERO_REG && (i_waddr == '0));

    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = i_waddr;
        mem_wdata = i_wdata;
        if (i_rst_n && (state == ST_CLEAR)) begin
            mem_we    = 1'b1;
            mem_waddr = cnt;
            mem_wdata = '0;
        end else if (wr_fire) begin
            mem_we = 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state <= ST_CLEAR;
            cnt   <= '0;
        end else begin
            case (state)
                ST_CLEAR: begin
                    cnt <= cnt + 1'b1;
                    if (cnt == ADDR_W'(DEPTH - 1)) begin
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    if (i_clr) begin
                        state <= ST_CLEAR;
                        cnt   <= '0;
                    end
                end
            endcase
        end
    end

    assign o_busy = (state == ST_CLEAR);

    always_comb begin
        o_rdata1 = mem[i_raddr1];
        if (o_busy || (ZERO_REG && (i_raddr1 == '0))) begin
            o_rdata1 = '0;
        end else if (wr_fire && (i_waddr == i_raddr1)) begin
            o_rdata1 = i_wdata;
        end
    end

    always_comb begin
        o_rdata2 = mem[i_raddr2];
        if (o_busy || (ZERO_REG && (i_raddr2 == '0))) begin
            o_rdata2 = '0;
        end else if (wr_fire && (i_waddr == i_raddr2)) begin
            o_rdata2 = i_wdata;
        end
    end

endmodule

// File: tb/tb_pipe_regfile.sv
// Directed bench for pipe_regfile: default build, ZERO_REG=0 build sharing its inputs, and a small 8x8 build.
module tb_pipe_regfile;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        clr, we;
    logic [4:0]  raddr1, raddr2, waddr;
    logic [31:0] wdata;
    logic [31:0] rd1_a, rd2_a, rd1_b, rd2_b;
    logic        busy_a, busy_b;

    logic        clr_c, we_c;
    logic [2:0]  raddr1_c, raddr2_c, waddr_c;
    logic [7:0]  wdata_c, rd1_c, rd2_c;
    logic        busy_c;

    always #5 clk = ~clk;

    pipe_regfile u_a (
        .i_clk(clk), .i_rst_n(rst_n), .i_clr(clr), .i_raddr1(raddr1), .i_raddr2(raddr2),
        .i_we(we), .i_waddr(waddr), .i_wdata(wdata), .o_rdata1(rd1_a), .o_rdata2(rd2_a), .o_busy(busy_a)
    );

    pipe_regfile #(.ZERO_REG(1'b0)) u_b (
        .i_clk(clk), .i_rst_n(rst_n), .i_clr(clr), .i_raddr1(raddr1), .i_raddr2(raddr2),
        .i_we(we), .i_waddr(waddr), .i_wdata(wdata), .o_rdata1(rd1_b), .o_rdata2(rd2_b), .o_busy(busy_b)
    );

    pipe_regfile #(.DATA_W(8), .ADDR_W(3)) u_c (
        .i_clk(clk), .i_rst_n(rst_n), .i_clr(clr_c), .i_raddr1(raddr1_c), .i_raddr2(raddr2_c),
        .i_we(we_c), .i_waddr(waddr_c), .i_wdata(wdata_c), .o_rdata1(rd1_c), .o_rdata2(rd2_c), .o_busy(busy_c)
    );

    typedef enum int { A_RD1, A_RD2, A_BUSY, B_RD1, B_BUSY, C_RD1, C_RD2, C_BUSY } sel_t;

    typedef struct {
        sel_t        sel;
        logic [31:0] exp;
        string       tag;
    } item_t;

    item_t q[$];
    int    total = 0;
    int    bad   = 0;

    function automatic logic [31:0] observe(sel_t sel);
        case (sel)
            A_RD1:   return rd1_a;
            A_RD2:   return rd2_a;
            A_BUSY:  return {31'd0, busy_a};
            B_RD1:   return rd1_b;
            B_BUSY:  return {31'd0, busy_b};
            C_RD1:   return {24'd0, rd1_c};
            C_RD2:   return {24'd0, rd2_c};
            default: return {31'd0, busy_c};
        endcase
    endfunction

    task automatic expect_val(sel_t sel, logic [31:0] e, string tag);
        item_t it;
        it.sel = sel;
        it.exp = e;
        it.tag = tag;
        q.push_back(it);
    endtask

    // Let combinational outputs settle, then compare everything queued for this cycle.
    task automatic drain();
        item_t       it;
        logic [31:0] obs;
        #1;
        while (q.size() > 0) begin
            it  = q.pop_front();
            obs = observe(it.sel);
            total++;
            assert (obs === it.exp) else begin
                bad++;
                $error("FAIL %s observed=%h expected=%h", it.tag, obs, it.exp);
            end
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0; clr = 1'b0; we = 1'b0; raddr1 = 5'd5; raddr2 = 5'd0; waddr = 5'd0; wdata = '0;
        clr_c = 1'b0; we_c = 1'b0; raddr1_c = 3'd5; raddr2_c = 3'd0; waddr_c = 3'd0; wdata_c = '0;

        tick();
        tick();
        expect_val(A_BUSY, 1, "reset_busy_a");
        expect_val(A_RD1, 0, "reset_rd1_a");
        expect_val(C_BUSY, 1, "reset_busy_c");
        expect_val(C_RD1, 0, "reset_rd1_c");
        drain();

        rst_n = 1'b1;
        for (int i = 0; i < 32; i++) begin
            raddr1 = 5'(i);
            expect_val(A_BUSY, 1, "sweep_busy_a");
            expect_val(B_BUSY, 1, "sweep_busy_b");
            expect_val(A_RD1, 0, "sweep_rd_zero");
            expect_val(C_BUSY, (i < 8) ? 1 : 0, "sweep_busy_c");
            drain();
            tick();
        end
        expect_val(A_BUSY, 0, "sweep_done_a");
        expect_val(B_BUSY, 0, "sweep_done_b");
        drain();
        for (int a = 0; a < 32; a++) begin
            raddr1 = 5'(a);
            raddr2 = 5'(31 - a);
            expect_val(A_RD1, 0, "post_sweep_rd1");
            expect_val(A_RD2, 0, "post_sweep_rd2");
            expect_val(B_RD1, 0, "post_sweep_b_rd1");
            drain();
        end
        for (int a = 0; a < 8; a++) begin
            raddr1_c = 3'(a);
            raddr2_c = 3'(7 - a);
            expect_val(C_RD1, 0, "post_sweep_c_rd1");
            expect_val(C_RD2, 0, "post_sweep_c_rd2");
            drain();
        end

        // Bypass write at 5 on the wide builds, 0xA5 at 7 on the small build.
        we = 1'b1; waddr = 5'd5; wdata = 32'hDEADBEEF; raddr1 = 5'd5; raddr2 = 5'd6;
        we_c = 1'b1; waddr_c = 3'd7; wdata_c = 8'hA5; raddr1_c = 3'd7; raddr2_c = 3'd7;
        expect_val(A_RD1, 32'hDEADBEEF, "bypass_rd1");
        expect_val(A_RD2, 0, "bypass_other_port");
        expect_val(B_RD1, 32'hDEADBEEF, "bypass_b_rd1");
        expect_val(C_RD1, 32'hA5, "small_bypass_rd1");
        expect_val(C_RD2, 32'hA5, "small_bypass_rd2");
        drain();
        tick();
        we = 1'b0; we_c = 1'b0;
        for (int i = 0; i < 2; i++) begin
            expect_val(A_RD1, 32'hDEADBEEF, "stored_rd1");
            expect_val(C_RD1, 32'hA5, "small_stored_rd1");
            expect_val(C_RD2, 32'hA5, "small_stored_rd2");
            drain();
            tick();
        end

        we = 1'b1; waddr = 5'd0; wdata = 32'h12345678; raddr1 = 5'd0; raddr2 = 5'd5;
        expect_val(A_RD1, 0, "zero_reg_bypass");
        expect_val(B_RD1, 32'h12345678, "no_zero_reg_bypass");
        expect_val(A_RD2, 32'hDEADBEEF, "zero_reg_other");
        drain();
        tick();
        we = 1'b0;
        expect_val(A_RD1, 0, "zero_reg_stored");
        expect_val(B_RD1, 32'h12345678, "no_zero_reg_stored");
        drain();

        // Overwrite 5 while reading it on both ports: new value must win over stored.
        we = 1'b1; waddr = 5'd5; wdata = 32'h0BADF00D; raddr1 = 5'd5; raddr2 = 5'd5;
        expect_val(A_RD1, 32'h0BADF00D, "overwrite_rd1");
        expect_val(A_RD2, 32'h0BADF00D, "overwrite_rd2");
        drain();
        tick();

        waddr = 5'd7; wdata = 32'h00000077; raddr1 = 5'd7;
        drain();
        tick();
        clr = 1'b1; we = 1'b1; waddr = 5'd7; wdata = 32'h11111111;
        expect_val(A_RD1, 32'h00000077, "clr_edge_no_bypass");
        expect_val(A_BUSY, 0, "clr_edge_idle");
        drain();
        tick();
        raddr2 = 5'd5;
        for (int i = 0; i < 32; i++) begin
            clr = i[0];
            we = ~i[0];
            wdata = 32'(i) + 32'h100;
            expect_val(A_BUSY, 1, "clr_sweep_busy");
            expect_val(A_RD1, 0, "clr_sweep_rd1");
            drain();
            tick();
        end
        clr = 1'b0; we = 1'b0;
        expect_val(A_BUSY, 0, "clr_sweep_done");
        expect_val(A_RD1, 0, "clr_entry7");
        expect_val(A_RD2, 0, "clr_entry5");
        expect_val(B_RD1, 0, "clr_entry7_b");
        drain();

        we = 1'b1; waddr = 5'd3; wdata = 32'h55; raddr1 = 5'd3;
        drain();
        tick();
        we = 1'b0; clr = 1'b1;
        expect_val(A_RD1, 32'h55, "pre_restart_stored");
        drain();
        tick();
        clr = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
        end
        rst_n = 1'b0;
        expect_val(A_BUSY, 1, "mid_sweep_busy");
        drain();
        tick();
        rst_n = 1'b1;
        expect_val(A_BUSY, 1, "restart_reset_busy");
        drain();
        for (int i = 0; i < 32; i++) begin
            expect_val(A_BUSY, 1, "restart_busy");
            drain();
            tick();
        end
        expect_val(A_BUSY, 0, "restart_done");
        expect_val(A_RD1, 0, "restart_entry3");
        raddr1_c = 3'd7;
        expect_val(C_BUSY, 0, "small_restart_done");
        expect_val(C_RD1, 0, "small_restart_entry7");
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pipe_regfile.md
PIPE_REGFILE -- requirements
Module: pipe_regfile

Interface
REQ-001 SHALL have parameter DATA_W, default 32, data word width in bits.
REQ-002 SHALL have parameter ADDR_W, default 5, address width; DEPTH = 2**ADDR_W entries.
REQ-003 SHALL have parameter ZERO_REG, default 1, when 1 entry 0 is hardwired to zero.
REQ-004 SHALL have port i_clk  input  1  clock, all state updates on rising edge.
REQ-005 SHALL have port i_rst_n  input  1  reset, synchronous, active-low.
REQ-006 SHALL have port i_clr  input  1  request to zero all entries, sampled in IDLE only.
REQ-007 SHALL have port i_raddr1  input  ADDR_W  read port 1 address.
REQ-008 SHALL have port i_raddr2  input  ADDR_W  read port 2 address.
REQ-009 SHALL have port i_we  input  1  write enable.
REQ-010 SHALL have port i_waddr  input  ADDR_W  write address.
REQ-011 SHALL have port i_wdata  input  DATA_W  write data.
REQ-012 SHALL have port o_rdata1  output  DATA_W  read port 1 data, combinational.
REQ-013 SHALL have port o_rdata2  output  DATA_W  read port 2 data, combinational.
REQ-014 SHALL have port o_busy  output  1  high while clear sweep in progress, driven from the state register.

Function
REQ-015 SHALL implement a two-state FSM: CLEAR (sweep) and IDLE (normal operation).
REQ-016 SHALL hold an ADDR_W-bit sweep counter; in CLEAR each rising edge writes zero to entry[cnt] and increments cnt.
REQ-017 SHALL transition CLEAR->IDLE on the edge that clears entry DEPTH-1; cnt wraps to 0.
REQ-018 SHALL, in IDLE with i_clr=1 at an edge, go to CLEAR with cnt=0; no entry is modified on that edge, and any i_we on that edge is dropped.
REQ-019 SHALL ignore i_clr while in CLEAR (no restart).
REQ-020 SHALL, in IDLE with i_we=1 and i_clr=0, write i_wdata to entry[i_waddr] at the edge; with ZERO_REG=1 a write to address 0 is discarded.
REQ-021 SHALL ignore i_we entirely while in CLEAR.
REQ-022 SHALL drive o_rdataN = 0 while in CLEAR, regardless of address.
REQ-023 SHALL drive o_rdataN = 0 when ZERO_REG=1 and i_raddrN = 0, in any state.
REQ-024 SHALL, in IDLE, bypass write data: if i_we=1, i_clr=0, i_waddr=i_raddrN and the write is not discarded, o_rdataN = i_wdata in the same cycle.
REQ-025 SHALL otherwise drive o_rdataN = entry[i_raddrN]; both ports are independent and may use the same address.
REQ-026 SHALL have zero-cycle read latency and one-cycle write latency (visible in storage after the write edge, visible at outputs in the write cycle via bypass).

Reset
REQ-027 SHALL, on any edge with i_rst_n=0, set state=CLEAR, cnt=0, with no entry modified and i_we/i_clr ignored, including mid-sweep (sweep restarts from 0).
REQ-028 SHALL have o_busy=1 and o_rdata1=o_rdata2=0 from the first reset edge onward.
REQ-029 SHALL keep o_busy high for exactly DEPTH rising edges after the first edge with i_rst_n=1, then deassert; all entries then read 0.

Verification
REQ-030 SHALL cover: reset 2 cycles, release -> o_busy high exactly 32 cycles (defaults), then 0; every address reads 0.
REQ-031 SHALL cover: IDLE, i_we=1 waddr=5 wdata=0xDEADBEEF, raddr1=5 same cycle -> o_rdata1=0xDEADBEEF in the write cycle and every later cycle.
REQ-032 SHALL cover: write 0x12345678 to address 0 with ZERO_REG=1 -> o_rdata1 reads 0 in the write cycle and after; with ZERO_REG=0 -> reads 0x12345678.
REQ-033 SHALL cover: i_clr=1 and i_we=1 (waddr=7) on the same edge -> write dropped, o_busy=1 for 32 cycles, entry 7 then reads 0; i_we pulses during sweep have no effect.
REQ-034 SHALL cover: reset asserted at sweep cycle 10 for 1 cycle -> after release o_busy high another full 32 cycles.
REQ-035 SHALL cover: ADDR_W=3, DATA_W=8 -> sweep of 8 cycles; write 0xA5 to entry 7, raddr1=raddr2=7 -> both ports 0xA5.
